// File: rtl/toeplitz_hash_if.sv
// Seed / raw-word / key handshake bundle for toeplitz_hash.
// master = seed loader + raw source + key consumer side, slave = hash block.
interface toeplitz_hash_if #(
    parameter int SEED_W = 3072,
    parameter int OUT_W  = 1024,
    parameter int DATA_W = 32
);
    logic              shift_en;
    logic [SEED_W-1:0] seed;
    logic              shift_ack;
    logic              raw_valid;
    logic [DATA_W-1:0] raw_data;
    logic              raw_ready;
    logic [OUT_W-1:0]  key_out;
    logic              key_valid;
    logic              key_ready;
    logic              busy;

    modport master (
        output shift_en, seed, raw_valid, raw_data, key_ready,
        input  shift_ack, raw_ready, key_out, key_valid, busy
    );

    modport slave (
        input  shift_en, seed, raw_valid, raw_data, key_ready,
        output shift_ack, raw_ready, key_out, key_valid, busy
    );
endinterface

// File: rtl/toeplitz_hash.sv
// Bit-serial Toeplitz hash: IN_BITS raw bits -> OUT_W-bit key using a SEED_W seed.
// Optional macro TOEPLITZ_KEEP_SEED_EN keeps a shadow copy of the seed for reuse across blocks.
module toeplitz_hash #(
    parameter int SEED_W = 3072,
    parameter int OUT_W  = 1024,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst,
    toeplitz_hash_if.slave    bus
);
    localparam int IN_BITS = SEED_W - OUT_W;
    localparam int WORDS   = IN_BITS / DATA_W;
    localparam int WCW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BCW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [WCW-1:0] W_LAST = WCW'(WORDS - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_HASH, S_OUT, S_RELOAD} state_t;

    state_t            r_state;
    logic [SEED_W-1:0] r_sreg;
    logic [OUT_W-1:0]  r_acc;
    logic [OUT_W-1:0]  r_key;
    logic [DATA_W-1:0] r_wbuf;
    logic [WCW-1:0]    r_word_cnt;
    logic [BCW-1:0]    r_bit_cnt;
    logic              r_ack;
    logic              r_kvld;
`ifdef TOEPLITZ_KEEP_SEED_EN
    logic [SEED_W-1:0] r_shadow;
`endif

    // Low OUT_W bits of the shifted seed are the Toeplitz window for the current input bit.
    logic [OUT_W-1:0] w_acc_nxt;
    assign w_acc_nxt = r_wbuf[0] ? (r_acc ^ r_sreg[OUT_W-1:0]) : r_acc;

    assign bus.shift_ack = r_ack;
    assign bus.key_valid = r_kvld;
    assign bus.key_out   = r_key;
    assign bus.raw_ready = (r_state == S_FETCH);
    assign bus.busy      = (r_state != S_IDLE);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_acc      <= '0;
            r_key      <= '0;
            r_wbuf     <= '0;
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ack      <= 1'b0;
            r_kvld     <= 1'b0;
`ifdef TOEPLITZ_KEEP_SEED_EN
            r_shadow   <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.shift_en) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_sreg     <= bus.seed;
`ifdef TOEPLITZ_KEEP_SEED_EN
                    r_shadow   <= bus.seed;
`endif
                    r_acc      <= '0;
                    r_word_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_ack      <= 1'b1;
                    r_state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.raw_valid) begin
                        r_wbuf  <= bus.raw_data;
                        r_state <= S_HASH;
                    end
                end
                S_HASH: begin
                    r_acc  <= w_acc_nxt;
                    r_sreg <= r_sreg >> 1;
                    r_wbuf <= r_wbuf >> 1;
                    if (r_bit_cnt == B_LAST) begin
                        r_bit_cnt <= '0;
                        if (r_word_cnt == W_LAST) begin
                            // Capture includes the final bit's contribution.
                            r_word_cnt <= '0;
                            r_key      <= w_acc_nxt;
                            r_kvld     <= 1'b1;
                            r_state    <= S_OUT;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (r_kvld && bus.key_ready) begin
                        r_kvld <= 1'b0;
`ifdef TOEPLITZ_KEEP_SEED_EN
                        r_state <= bus.shift_en ? S_LOAD : S_RELOAD;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
`ifdef TOEPLITZ_KEEP_SEED_EN
                S_RELOAD: begin
                    r_sreg     <= r_shadow;
                    r_acc      <= '0;
                    r_word_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_state    <= S_FETCH;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toeplitz_hash.sv
// Directed self-checking bench for toeplitz_hash (default seed/key/word widths).
module tb_toeplitz_hash;
    localparam int SEED_W  = 3072;
    localparam int OUT_W   = 1024;
    localparam int DATA_W  = 32;
    localparam int IN_BITS = SEED_W - OUT_W;
    localparam int WORDS   = IN_BITS / DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    toeplitz_hash_if #(.SEED_W(SEED_W), .OUT_W(OUT_W), .DATA_W(DATA_W)) bus ();
    toeplitz_hash #(.SEED_W(SEED_W), .OUT_W(OUT_W), .DATA_W(DATA_W)) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int acks = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.shift_ack) acks <= acks + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Definition: XOR of seed[i+OUT_W-1:i] for every set input bit i.
    function automatic logic [OUT_W-1:0] model(input logic [SEED_W-1:0] s, input logic [IN_BITS-1:0] x);
        logic [OUT_W-1:0]  k;
        logic [SEED_W-1:0] t;
        k = '0;
        for (int i = 0; i < IN_BITS; i++)
            if (x[i]) begin
                t = s >> i;
                k ^= t[OUT_W-1:0];
            end
        return k;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [SEED_W-1:0] s);
`ifdef TOEPLITZ_KEEP_SEED_EN
        if (bus.busy) begin rst = 1'b1; #1; rst = 1'b0; end
`endif
        bus.seed = s;
        bus.shift_en = 1'b1;
        tick; tick;
        checks++;
        if (bus.shift_ack !== 1'b1) begin
            errs++; $display("FAIL handshake_ack: got %b want 1", bus.shift_ack);
        end
        bus.shift_en = 1'b0;
    endtask

    task automatic send_words(input logic [IN_BITS-1:0] blk, input int n);
        for (int w = 0; w < n; w++) begin
            int n_wait;
            n_wait = 0;
            bus.raw_valid = 1'b1;
            bus.raw_data = blk[w*DATA_W +: DATA_W];
            while (bus.raw_ready !== 1'b1 && n_wait < 100) begin tick; n_wait++; end
            if (n_wait >= 100) begin
                checks++; errs++;
                $display("FAIL raw_ready_timeout: word %0d got ready=%b want 1", w, bus.raw_ready);
                bus.raw_valid = 1'b0;
                return;
            end
            tick;
        end
        bus.raw_valid = 1'b0;
    endtask

    task automatic wait_key(output logic [OUT_W-1:0] k);
        int n;
        n = 0;
        while (bus.key_valid !== 1'b1 && n < 200) begin tick; n++; end
        checks++;
        if (bus.key_valid !== 1'b1) begin
            errs++; $display("FAIL key_valid_timeout: got %b want 1", bus.key_valid);
        end
        k = bus.key_out;
    endtask

    task automatic release_key;
        bus.key_ready = 1'b1;
        tick;
        bus.key_ready = 1'b0;
        checks++;
        if (bus.key_valid !== 1'b0) begin
            errs++; $display("FAIL release_kvld: got %b want 0", bus.key_valid);
        end
`ifndef TOEPLITZ_KEEP_SEED_EN
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++; $display("FAIL release_idle: busy got %b want 0", bus.busy);
        end
`endif
    endtask

    task automatic make_seed(input int salt, output logic [SEED_W-1:0] s);
        for (int i = 0; i < SEED_W/32; i++) s[i*32 +: 32] = (32'h9E3779B9 * (i + salt)) ^ 32'h5A5A0F0F;
    endtask

    task automatic make_blk(input int salt, output logic [IN_BITS-1:0] b);
        for (int i = 0; i < WORDS; i++) b[i*32 +: 32] = (32'h85EBCA6B * (i + salt)) ^ 32'hC2B2AE35;
    endtask

    task automatic test_reset;
        bus.shift_en = 1'b0; bus.seed = '0; bus.raw_valid = 1'b0;
        bus.raw_data = '0; bus.key_ready = 1'b0;
        rst = 1'b1;
        tick; tick;
        checks += 5;
        if (bus.shift_ack !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b want 0", bus.shift_ack); end
        if (bus.raw_ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", bus.raw_ready); end
        if (bus.key_valid !== 1'b0) begin errs++; $display("FAIL reset_kvld: got %b want 0", bus.key_valid); end
        if (bus.key_out !== '0) begin errs++; $display("FAIL reset_key: got nonzero want 0"); end
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_bit;
        logic [SEED_W-1:0]  s;
        logic [IN_BITS-1:0] b;
        logic [OUT_W-1:0]   k, e;
        int t0;
        s = '0; s[0] = 1'b1;
        b = '0; b[0] = 1'b1;
        e = '0; e[0] = 1'b1;
        t0 = cyc;
        handshake(s);
        send_words(b, WORDS);
        wait_key(k);
        checks += 2;
        if (k !== e) begin errs++; $display("FAIL single_bit_key: got %h want 1", k[31:0]); end
        if (cyc - t0 !== 2 + WORDS*(1+DATA_W)) begin
            errs++; $display("FAIL single_bit_latency: got %0d want %0d", cyc - t0, 2 + WORDS*(1+DATA_W));
        end
        release_key;
    endtask

    task automatic test_all_ones;
        logic [SEED_W-1:0]  s;
        logic [IN_BITS-1:0] b;
        logic [OUT_W-1:0]   k, e;
        s = '0; s[OUT_W-1] = 1'b1;
        b = '1;
        e = '1;
        handshake(s);
        send_words(b, WORDS);
        wait_key(k);
        checks++;
        if (k !== e) begin errs++; $display("FAIL all_ones_key: got %h.. want ffffffff..", k[OUT_W-1 -: 32]); end
        release_key;
    endtask

    task automatic test_linearity;
        logic [SEED_W-1:0]  s;
        logic [IN_BITS-1:0] a, b;
        logic [OUT_W-1:0]   ka, kb, kab;
        make_seed(3, s);
        make_blk(1, a);
        make_blk(7, b);
        handshake(s); send_words(a, WORDS); wait_key(ka); release_key;
        handshake(s); send_words(b, WORDS); wait_key(kb); release_key;
        handshake(s); send_words(a ^ b, WORDS); wait_key(kab); release_key;
        checks += 4;
        if (ka !== model(s, a)) begin errs++; $display("FAIL lin_key_a: got %h want %h", ka[31:0], model(s, a) & 32'hFFFFFFFF); end
        if (kb !== model(s, b)) begin errs++; $display("FAIL lin_key_b: got %h want %h", kb[31:0], model(s, b) & 32'hFFFFFFFF); end
        if (kab !== model(s, a ^ b)) begin errs++; $display("FAIL lin_key_ab: got %h want %h", kab[31:0], model(s, a ^ b) & 32'hFFFFFFFF); end
        if ((ka ^ kb) !== kab) begin errs++; $display("FAIL lin_xor: got %h want %h", (ka ^ kb) & 32'hFFFFFFFF, kab[31:0]); end
    endtask

    task automatic test_hold;
        logic [SEED_W-1:0]  s;
        logic [IN_BITS-1:0] a;
        logic [OUT_W-1:0]   k, e;
        make_seed(11, s);
        make_blk(5, a);
        e = model(s, a);
        handshake(s);
        send_words(a, WORDS);
        wait_key(k);
        bus.raw_valid = 1'b1;
        bus.key_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks += 3;
            if (bus.key_valid !== 1'b1) begin errs++; $display("FAIL hold_kvld: cycle %0d got %b want 1", i, bus.key_valid); end
            if (bus.key_out !== e) begin errs++; $display("FAIL hold_key: cycle %0d got %h want %h", i, bus.key_out[31:0], e[31:0]); end
            if (bus.raw_ready !== 1'b0) begin errs++; $display("FAIL hold_ready: cycle %0d got %b want 0", i, bus.raw_ready); end
        end
        bus.raw_valid = 1'b0;
        release_key;
    endtask

    task automatic test_reset_mid;
        logic [SEED_W-1:0]  s, s2;
        logic [IN_BITS-1:0] a, b;
        logic [OUT_W-1:0]   k;
        make_seed(21, s);
        make_seed(33, s2);
        make_blk(9, a);
        make_blk(13, b);
        handshake(s);
        send_words(a, 21);
        tick; tick; tick; tick; tick;
        rst = 1'b1;
        tick;
        checks += 5;
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
        if (bus.raw_ready !== 1'b0) begin errs++; $display("FAIL mid_rst_ready: got %b want 0", bus.raw_ready); end
        if (bus.key_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_kvld: got %b want 0", bus.key_valid); end
        if (bus.key_out !== '0) begin errs++; $display("FAIL mid_rst_key: got nonzero want 0"); end
        if (bus.shift_ack !== 1'b0) begin errs++; $display("FAIL mid_rst_ack: got %b want 0", bus.shift_ack); end
        rst = 1'b0;
        tick;
        bus.seed = s2;
        bus.shift_en = 1'b1;
        tick;
        checks++;
        if (bus.shift_ack !== 1'b0) begin errs++; $display("FAIL ack_early: got %b want 0", bus.shift_ack); end
        tick;
        checks++;
        if (bus.shift_ack !== 1'b1) begin errs++; $display("FAIL ack_at_2: got %b want 1", bus.shift_ack); end
        bus.shift_en = 1'b0;
        tick;
        checks++;
        if (bus.shift_ack !== 1'b0) begin errs++; $display("FAIL ack_pulse_len: got %b want 0", bus.shift_ack); end
        send_words(b, WORDS);
        wait_key(k);
        checks++;
        if (k !== model(s2, b)) begin errs++; $display("FAIL mid_rst_newkey: got %h want %h", k[31:0], model(s2, b) & 32'hFFFFFFFF); end
        release_key;
    endtask

    task automatic test_back_to_back;
        logic [SEED_W-1:0]  s;
        logic [IN_BITS-1:0] a, b;
        logic [OUT_W-1:0]   ka, kb;
        int a0;
        make_seed(41, s);
        make_blk(17, a);
        make_blk(19, b);
        a0 = acks;
        handshake(s);
        send_words(a, WORDS);
        wait_key(ka);
        release_key;
`ifndef TOEPLITZ_KEEP_SEED_EN
        for (int i = 0; i < 5; i++) tick;
        checks += 2;
        if (bus.busy !== 1'b0) begin errs++; $display("FAIL b2b_idle_busy: got %b want 0", bus.busy); end
        if (bus.raw_ready !== 1'b0) begin errs++; $display("FAIL b2b_idle_ready: got %b want 0", bus.raw_ready); end
        handshake(s);
`endif
        send_words(b, WORDS);
        wait_key(kb);
        release_key;
        tick;
        checks += 3;
        if (ka !== model(s, a)) begin errs++; $display("FAIL b2b_key_a: got %h want %h", ka[31:0], model(s, a) & 32'hFFFFFFFF); end
        if (kb !== model(s, b)) begin errs++; $display("FAIL b2b_key_b: got %h want %h", kb[31:0], model(s, b) & 32'hFFFFFFFF); end
`ifdef TOEPLITZ_KEEP_SEED_EN
        if (acks - a0 !== 1) begin errs++; $display("FAIL b2b_ack_count: got %0d want 1", acks - a0); end
`else
        if (acks - a0 !== 2) begin errs++; $display("FAIL b2b_ack_count: got %0d want 2", acks - a0); end
`endif
    endtask

    initial begin
        test_reset;
        test_single_bit;
        test_all_ones;
        test_linearity;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
